spi_word_rx: RTL and testbench

SPI slave front end that deserialises 32-bit command words from the host MCU and presents each word on DATA with a one-cycle DATA_READY strobe. DINTERP, directly downstream, consumes these.
- Shifts read-back data (TX_DATA) out on MISO during the next word, so register reads decoded by DINTERP can be returned over the same link.
- All SPI pins are asynchronous to clk and are synchronised inside the block.

---
 rtl/spi_word_rx_pkg.sv | 13 +
 rtl/spi_word_rx_sync_edge.sv | 33 +++
 rtl/spi_word_rx.sv | 160 ++++++++++++++++
 tb/tb_spi_word_rx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_word_rx_pkg.sv
// Shared widths and state encoding for the SPI command-word receiver.
// The widths match the DATA/RDATA ports of the DINTERP block downstream.
package spi_word_rx_pkg;

  localparam int SPI_WORD_WIDTH = 32;
  localparam int SPI_TX_WIDTH   = 16;

  typedef enum logic {
    IDLE,
    SHIFT
  } spi_state_t;

endpackage

// File: rtl/spi_word_rx_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pin, with single-cycle rise/fall
// pulses derived from one extra flop behind the synchronised value.
module spi_sync_edge
  import spi_word_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_word_rx.sv
// SPI mode-0 slave front end: deserialises command words from the host and
// shifts read-back data out on MISO during the following word.
module spi_word_rx
  import spi_word_rx_pkg::*;
#(
  parameter int WORD_WIDTH  = SPI_WORD_WIDTH,
  parameter int TX_WIDTH    = SPI_TX_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SCK,
  input  logic                  CS_N,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [TX_WIDTH-1:0]   TX_DATA,
  output logic [WORD_WIDTH-1:0] DATA,
  output logic                  DATA_READY,
  output logic                  FRAME_ERR
);

  localparam int CNT_W = $clog2(WORD_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

  logic sck_sync, sck_rise, sck_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic mosi_sync;

  spi_state_t            state_q, state_n;
  logic                  armed_q, armed_n;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_n;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_n;
  logic [TX_WIDTH-1:0]   txreg_q, txreg_n;
  logic                  skip_q, skip_n;
  logic [WORD_WIDTH-1:0] data_q, data_n;
  logic                  ready_q, ready_n;
  logic                  err_q, err_n;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (SCK),
    .sync (sck_sync),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (CS_N),
    .sync (cs_sync),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // MOSI has the same depth as SCK so it lines up with the synchronised rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_chain <= '0;
    end else begin
      mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], MOSI};
    end
  end

  assign mosi_sync = mosi_chain[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      txreg_q   <= '0;
      skip_q    <= 1'b0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      armed_q   <= armed_n;
      bit_cnt_q <= bit_cnt_n;
      shreg_q   <= shreg_n;
      txreg_q   <= txreg_n;
      skip_q    <= skip_n;
      data_q    <= data_n;
      ready_q   <= ready_n;
      err_q     <= err_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    armed_n   = armed_q;
    bit_cnt_n = bit_cnt_q;
    shreg_n   = shreg_q;
    txreg_n   = txreg_q;
    skip_n    = skip_q;
    data_n    = data_q;
    ready_n   = 1'b0;
    err_n     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_sync) begin
          armed_n = 1'b1;
        end
        // A fall only precedes the first rise if SCK was high when the frame opened.
        if (cs_fall && armed_q) begin
          state_n   = SHIFT;
          armed_n   = 1'b0;
          bit_cnt_n = '0;
          shreg_n   = '0;
          txreg_n   = TX_DATA;
          skip_n    = sck_sync;
        end
      end

      SHIFT: begin
        if (sck_rise) begin
          shreg_n = {shreg_q[WORD_WIDTH-2:0], mosi_sync};
          if (bit_cnt_q == LAST_BIT) begin
            data_n    = {shreg_q[WORD_WIDTH-2:0], mosi_sync};
            ready_n   = 1'b1;
            bit_cnt_n = '0;
            txreg_n   = TX_DATA;
            skip_n    = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt_q + 1'b1;
          end
        end else if (sck_fall) begin
          if (skip_q) begin
            skip_n = 1'b0;
          end else begin
            txreg_n = {txreg_q[TX_WIDTH-2:0], 1'b0};
          end
        end

        // Using the post-rise count lets a final bit and CS_N rise coincide cleanly.
        if (cs_rise) begin
          if (bit_cnt_n != '0) begin
            err_n = 1'b1;
          end
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign MISO       = (state_q == SHIFT) ? txreg_q[TX_WIDTH-1] : 1'b0;
  assign DATA       = data_q;
  assign DATA_READY = ready_q;
  assign FRAME_ERR  = err_q;

endmodule

// File: tb/tb_spi_word_rx.sv
// Self-checking bench for spi_word_rx: directed scenarios plus randomized frames
// compared against a word-level model of the SPI link.
`timescale 1ns/1ps
module tb_spi_word_rx;

  localparam int HALF = 50;

  logic        clk;
  logic        rst;
  logic        SCK;
  logic        CS_N;
  logic        MOSI;
  logic        MISO;
  logic [15:0] TX_DATA;
  logic [31:0] DATA;
  logic        DATA_READY;
  logic        FRAME_ERR;

  int check_count = 0;
  int pass_count  = 0;

  int err_cnt      = 0;
  int wide_cnt     = 0;
  int unstable_cnt = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] prev_data = '0;
  logic        prev_ready = 1'b0;
  logic        prev_err = 1'b0;

  spi_word_rx dut (
    .clk        (clk),
    .rst        (rst),
    .SCK        (SCK),
    .CS_N       (CS_N),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .TX_DATA    (TX_DATA),
    .DATA       (DATA),
    .DATA_READY (DATA_READY),
    .FRAME_ERR  (FRAME_ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watches the output strobes and records every committed word.
  always @(negedge clk) begin
    if (DATA_READY === 1'b1) begin
      got_q.push_back(DATA);
      if (prev_ready === 1'b1) wide_cnt++;
    end
    if (FRAME_ERR === 1'b1) begin
      err_cnt++;
      if (prev_err === 1'b1) wide_cnt++;
    end
    if (rst === 1'b0 && DATA_READY !== 1'b1 && DATA !== prev_data) unstable_cnt++;
    prev_data  = DATA;
    prev_ready = DATA_READY;
    prev_err   = FRAME_ERR;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
  endtask

  // Clocks nbits of word MSB-first; MISO is captured at each SCK rise.
  task automatic applyStimulus(input logic [31:0] word, input int nbits, input int change_at,
                               input logic [15:0] tx_next, output logic [31:0] miso_vec);
    miso_vec = '0;
    for (int i = 0; i < nbits; i++) begin
      if (i == change_at) TX_DATA = tx_next;
      MOSI = word[31-i];
      #HALF;
      miso_vec[31-i] = MISO;
      SCK = 1'b1;
      #HALF;
      SCK = 1'b0;
    end
  endtask

  task automatic openFrame();
    CS_N = 1'b0;
    #100;
  endtask

  task automatic closeFrame();
    #100;
    CS_N = 1'b1;
    #200;
  endtask

  task automatic checkWords(input string tag);
    logic [31:0] exp_w, got_w;
    checkOutput({tag, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      got_w = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      checkOutput({tag, " word"}, got_w, exp_w);
    end
    got_q.delete();
  endtask

  initial begin
    logic [31:0] miso_vec;
    logic [31:0] word;
    logic [31:0] last_word;
    logic [15:0] tx, tx_next;
    int          err_base;
    int          nwords;
    logic        miso_any;

    rst = 1'b1; CS_N = 1'b1; SCK = 1'b0; MOSI = 1'b0; TX_DATA = '0;
    #32;
    checkOutput("reset DATA", DATA, 32'h0);
    checkOutput("reset DATA_READY", 32'(DATA_READY), 32'h0);
    checkOutput("reset FRAME_ERR", 32'(FRAME_ERR), 32'h0);
    checkOutput("reset MISO", 32'(MISO), 32'h0);
    rst = 1'b0;
    #100;

    $display("[TB] single word frame");
    err_base = err_cnt;
    TX_DATA = 16'hA4A4;
    #50;
    openFrame();
    applyStimulus(32'hCA33A3A3, 32, -1, 16'h0, miso_vec);
    exp_q.push_back(32'hCA33A3A3);
    closeFrame();
    checkWords("frame1");
    checkOutput("frame1 DATA held", DATA, 32'hCA33A3A3);
    checkOutput("frame1 FRAME_ERR", 32'(err_cnt - err_base), 32'h0);
    checkOutput("frame1 MISO", miso_vec, {16'hA4A4, 16'h0});

    $display("[TB] two words in one frame with read-back reload");
    err_base = err_cnt;
    openFrame();
    applyStimulus(32'h8040A4A4, 32, 20, 16'h1234, miso_vec);
    checkOutput("word1 MISO", miso_vec, {16'hA4A4, 16'h0});
    applyStimulus(32'h0040A4A4, 32, -1, 16'h0, miso_vec);
    checkOutput("word2 MISO", miso_vec, {16'h1234, 16'h0});
    exp_q.push_back(32'h8040A4A4);
    exp_q.push_back(32'h0040A4A4);
    closeFrame();
    checkWords("frame2");
    checkOutput("frame2 FRAME_ERR", 32'(err_cnt - err_base), 32'h0);
    last_word = 32'h0040A4A4;

    $display("[TB] frame aborted after 20 bits");
    err_base = err_cnt;
    openFrame();
    applyStimulus(32'hDEADBEEF, 20, -1, 16'h0, miso_vec);
    closeFrame();
    checkOutput("abort FRAME_ERR", 32'(err_cnt - err_base), 32'h1);
    checkWords("abort");
    checkOutput("abort DATA held", DATA, last_word);
    word = $urandom;
    openFrame();
    applyStimulus(word, 32, -1, 16'h0, miso_vec);
    exp_q.push_back(word);
    closeFrame();
    checkWords("after abort");

    $display("[TB] reset in the middle of a frame");
    openFrame();
    applyStimulus(32'h13572468, 10, -1, 16'h0, miso_vec);
    #22 rst = 1'b1;
    #20 rst = 1'b0;
    #8;
    err_base = err_cnt;
    applyStimulus(32'h13572468 << 10, 22, -1, 16'h0, miso_vec);
    closeFrame();
    checkWords("reset mid");
    checkOutput("reset mid FRAME_ERR", 32'(err_cnt - err_base), 32'h0);
    checkOutput("reset mid DATA", DATA, 32'h0);
    word = $urandom;
    openFrame();
    applyStimulus(word, 32, -1, 16'h0, miso_vec);
    exp_q.push_back(word);
    closeFrame();
    checkWords("after reset");

    $display("[TB] SCK toggling with CS_N high");
    err_base = err_cnt;
    miso_any = 1'b0;
    for (int i = 0; i < 40; i++) begin
      MOSI = 1'($urandom);
      #HALF;
      miso_any = miso_any | MISO;
      SCK = 1'b1;
      #HALF;
      miso_any = miso_any | MISO;
      SCK = 1'b0;
    end
    #200;
    checkWords("idle sck");
    checkOutput("idle FRAME_ERR", 32'(err_cnt - err_base), 32'h0);
    checkOutput("idle MISO", 32'(miso_any), 32'h0);

    $display("[TB] randomized frames");
    err_base = err_cnt;
    for (int f = 0; f < 6; f++) begin
      nwords = $urandom_range(1, 3);
      tx = 16'($urandom);
      TX_DATA = tx;
      #50;
      openFrame();
      for (int w = 0; w < nwords; w++) begin
        word = $urandom;
        tx_next = 16'($urandom);
        applyStimulus(word, 32, $urandom_range(17, 29), tx_next, miso_vec);
        checkOutput("random MISO", miso_vec, {tx, 16'h0});
        exp_q.push_back(word);
        tx = tx_next;
      end
      closeFrame();
      checkWords("random");
    end
    checkOutput("random FRAME_ERR", 32'(err_cnt - err_base), 32'h0);

    checkOutput("strobe width", 32'(wide_cnt), 32'h0);
    checkOutput("DATA stability", 32'(unstable_cnt), 32'h0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
